pulse_shaper: RTL and testbench

PULSE_SHAPER -- requirements
Module: pulse_shaper

---
 rtl/pulse_shaper.sv | 72 +++++++
 tb/tb_pulse_shaper.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pulse_shaper.sv
// pulse_shaper: turns request strobes into fixed-width high pulses separated by guaranteed low gaps,
// queueing requests that arrive while a pulse is in progress.
module pulse_shaper #(
  parameter int HIGH_CYCLES = 2,
  parameter int GAP_CYCLES  = 1,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pulse,
  output logic              level,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);
  localparam int MX = HIGH_CYCLES > GAP_CYCLES ? HIGH_CYCLES : GAP_CYCLES;
  localparam int CW = MX > 1 ? $clog2(MX) : 1;
  localparam logic [CW-1:0] H_LD = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] G_LD = CW'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PMAX = '1;
  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [PEND_W-1:0] pend_nx;
  logic ovf_nx, last, gap_exit, consume, direct, inc;
  assign last     = cnt == '0;
  assign gap_exit = state == GAP && last;
  assign consume  = gap_exit && pending != '0;
  assign direct   = pulse && (state == IDLE || (gap_exit && pending == '0));
  assign inc      = pulse && !direct;
  always_comb begin
    state_nx = state;
    cnt_nx   = last ? cnt : cnt - 1'b1;
    case (state)
      IDLE: begin
        state_nx = pulse ? HIGH : IDLE;
        cnt_nx   = pulse ? H_LD : '0;
      end
      HIGH: if (last) begin
        state_nx = GAP;
        cnt_nx   = G_LD;
      end
      GAP: if (last) begin
        state_nx = (pending != '0 || pulse) ? HIGH : IDLE;
        cnt_nx   = (pending != '0 || pulse) ? H_LD : '0;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end
  // a request at saturation is dropped only if nothing leaves the queue on the same edge
  assign ovf_nx  = overflow || (inc && !consume && pending == PMAX);
  assign pend_nx = (inc && !consume && pending == PMAX) ? pending
                 : pending + PEND_W'(inc) - PEND_W'(consume);
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      pending  <= pend_nx;
      overflow <= ovf_nx;
    end
  end
  assign level = state == HIGH;
  assign busy  = state != IDLE;
endmodule

// File: tb/tb_pulse_shaper.sv
// tb_pulse_shaper: directed and random checks of pulse_shaper against a start-time based reference model.
module tb_pulse_shaper;
  localparam int H = 2, G = 1, PW = 3;
  localparam int PMAX = (1 << PW) - 1;
  logic clk = 0, reset = 0, pulse = 0;
  logic level, busy, overflow;
  logic [PW-1:0] pending;
  int n_tests = 0, n_fail = 0;
  int m_t = 0, m_start = 0, m_pend = 0, m_rises = 0, d_rises = 0;
  bit m_active = 0, m_ovf = 0, prev_level = 0;
  logic [PW+2:0] dut_out;

  pulse_shaper #(.HIGH_CYCLES(H), .GAP_CYCLES(G), .PEND_W(PW)) dut (
    .clk(clk), .reset(reset), .pulse(pulse),
    .level(level), .busy(busy), .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;
  assign dut_out = {level, busy, pending, overflow};

  function automatic logic [PW+2:0] exp_out();
    int e = m_t - m_start;
    return {m_active && e < H, m_active && e < H + G, PW'(m_pend), m_ovf};
  endfunction

  // model: a waveform started at edge s is high for edges s..s+H-1, low gap until s+H+G, where the next may start
  task automatic tick(input bit p, input bit r);
    int e;
    pulse = p;
    reset = r;
    @(posedge clk);
    m_t++;
    e = m_t - m_start;
    if (!r) begin
      m_active = 0; m_pend = 0; m_ovf = 0;
    end else if (m_active && e < H + G) begin
      if (p && m_pend == PMAX) m_ovf = 1;
      else if (p) m_pend++;
    end else if (m_active && e == H + G && m_pend > 0) begin
      m_pend += int'(p) - 1;
      m_start = m_t; m_rises++;
    end else if (p) begin
      m_active = 1; m_start = m_t; m_rises++;
    end else m_active = 0;
    #1;
    if (level === 1'b1 && !prev_level) d_rises++;
    prev_level = level === 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1, 0);
      n_tests++;
      if (dut_out !== exp_out() || dut_out !== '0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %b exp %b", i, dut_out, exp_out());
      end
    end
  endtask

  task automatic test_single();
    int r0 = d_rises;
    tick(1, 1);
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (dut_out !== exp_out()) begin
        n_fail++;
        $display("FAIL single[%0d]: got %b exp %b", i, dut_out, exp_out());
      end
      tick(0, 1);
    end
    n_tests++;
    if (d_rises - r0 != 1) begin
      n_fail++;
      $display("FAIL single_rises: got %0d exp 1", d_rises - r0);
    end
  endtask

  task automatic test_back_to_back();
    int r0 = d_rises;
    tick(1, 1);
    tick(1, 1);
    n_tests++;
    if (pending !== 3'd1 || level !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_pend: got pending %0d level %b exp 1 1", pending, level);
    end
    for (int i = 0; i < 7; i++) begin
      tick(0, 1);
      n_tests++;
      if (dut_out !== exp_out()) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got %b exp %b", i, dut_out, exp_out());
      end
    end
    n_tests++;
    if (d_rises - r0 != 2) begin
      n_fail++;
      $display("FAIL b2b_rises: got %0d exp 2", d_rises - r0);
    end
  endtask

  task automatic test_gap_exit();
    bit seq [6] = '{1, 0, 0, 1, 0, 0};
    for (int i = 0; i < 6; i++) begin
      tick(seq[i], 1);
      n_tests++;
      if (dut_out !== exp_out() || (i < 5 && busy !== 1'b1)) begin
        n_fail++;
        $display("FAIL gap_exit[%0d]: got %b exp %b", i, dut_out, exp_out());
      end
    end
    for (int i = 0; i < 3; i++) tick(0, 1);
  endtask

  task automatic test_saturation();
    int r0 = d_rises, m0 = m_rises;
    bit saw7 = 0;
    for (int i = 0; i < 50; i++) begin
      tick(i < 12, 1);
      saw7 |= pending === 3'd7;
      n_tests++;
      if (dut_out !== exp_out()) begin
        n_fail++;
        $display("FAIL sat[%0d]: got %b exp %b", i, dut_out, exp_out());
      end
    end
    n_tests++;
    if (!saw7 || overflow !== 1'b1 || pending !== '0 || d_rises - r0 != m_rises - m0) begin
      n_fail++;
      $display("FAIL sat_end: got saw7 %b ovf %b pend %0d rises %0d exp 1 1 0 %0d",
               saw7, overflow, pending, d_rises - r0, m_rises - m0);
    end
  endtask

  task automatic test_after_overflow();
    int r0 = d_rises;
    tick(1, 1);
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (dut_out !== exp_out() || overflow !== 1'b1) begin
        n_fail++;
        $display("FAIL after_ovf[%0d]: got %b exp %b", i, dut_out, exp_out());
      end
      tick(0, 1);
    end
    n_tests++;
    if (d_rises - r0 != 1) begin
      n_fail++;
      $display("FAIL after_ovf_rises: got %0d exp 1", d_rises - r0);
    end
  endtask

  task automatic test_reset_mid();
    int r0;
    tick(0, 0);
    for (int i = 0; i < 4; i++) tick(1, 1);
    n_tests++;
    if (pending !== 3'd2 || level !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_setup: got pending %0d level %b exp 2 1", pending, level);
    end
    tick(1, 0);
    r0 = d_rises;
    n_tests++;
    if (dut_out !== '0 || dut_out !== exp_out()) begin
      n_fail++;
      $display("FAIL mid_reset: got %b exp 0", dut_out);
    end
    for (int i = 0; i < 8; i++) tick(0, 1);
    n_tests++;
    if (d_rises != r0 || dut_out !== '0) begin
      n_fail++;
      $display("FAIL mid_quiet: got rises %0d out %b exp 0 0", d_rises - r0, dut_out);
    end
  endtask

  task automatic test_random();
    tick(0, 0);
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(99) < 45, $urandom_range(79) != 0);
      n_tests++;
      if (dut_out !== exp_out()) begin
        n_fail++;
        $display("FAIL random[%0d]: got %b exp %b", i, dut_out, exp_out());
      end
    end
    for (int i = 0; i < 40; i++) tick(0, 1);
    n_tests++;
    if (d_rises != m_rises || dut_out !== exp_out()) begin
      n_fail++;
      $display("FAIL random_rises: got %0d exp %0d", d_rises, m_rises);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap_exit();
    test_saturation();
    test_after_overflow();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
